six_bit_div: RTL and testbench

- Sequential 6-bit unsigned restoring divider producing quotient, remainder and a divide-by-zero overflow flag.
- Sits in the calculator datapath as the division functional unit.
- Uses a start/busy/done handshake with a fixed latency and a single clock domain.

---
 rtl/six_bit_div_pkg.sv | 10 +
 rtl/six_bit_div_if.sv | 23 ++
 rtl/six_bit_div_step.sv | 19 +
 rtl/six_bit_div.sv | 86 ++++++++
 tb/tb_six_bit_div.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/six_bit_div_pkg.sv
// Shared widths and state encoding for the six_bit_div divider.
package six_bit_div_pkg;
    localparam int W  = 6;
    localparam int CW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/six_bit_div_if.sv
// start/busy/done bundle between the datapath and the divider.
interface six_bit_div_if;
    import six_bit_div_pkg::*;

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, overflow, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, overflow, busy, done
    );
endinterface

// File: rtl/six_bit_div_step.sv
// One restoring division step: shift in a bit, trial-subtract, restore.
module six_bit_div_step
    import six_bit_div_pkg::*;
(
    input  logic [W-1:0] prem,
    input  logic         din,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] nrem,
    output logic         qbit
);
    logic [W:0] sh;
    logic [W:0] trial;

    // 7-bit shifted remainder keeps the compare/subtract from wrapping
    assign sh    = {prem, din};
    assign trial = sh - {1'b0, dvs};
    assign qbit  = (sh >= {1'b0, dvs});
    assign nrem  = qbit ? trial[W-1:0] : sh[W-1:0];
endmodule

// File: rtl/six_bit_div.sv
// Sequential 6-bit unsigned restoring divider, one quotient bit per cycle.
module six_bit_div
    import six_bit_div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    six_bit_div_if.slave bus
);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] bidx;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W-1:0]  prem;
    logic [W-1:0]  qacc;
    logic [W-1:0]  nrem;
    logic          qbit;
    logic          last;
    logic          divz;

    assign bidx = LAST - cnt;
    assign last = (state == RUN) && (cnt == LAST);
    assign divz = (dvs == '0);

    six_bit_div_step u_step (
        .prem (prem),
        .din  (dvd[bidx]),
        .dvs  (dvs),
        .nrem (nrem),
        .qbit (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN:  if (last)      state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            prem          <= '0;
            qacc          <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.overflow  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                dvd      <= bus.dividend;
                dvs      <= bus.divisor;
                prem     <= '0;
                qacc     <= '0;
                cnt      <= '0;
                bus.busy <= 1'b1;
            end else if (state == RUN) begin
                prem <= nrem;
                qacc <= {qacc[W-2:0], qbit};
                cnt  <= cnt + 1'b1;
                if (last) begin
                    // divide-by-zero result forced, not left to the algorithm
                    bus.quotient  <= divz ? '1 : {qacc[W-2:0], qbit};
                    bus.remainder <= divz ? dvd : nrem;
                    bus.overflow  <= divz;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_six_bit_div.sv
// Self-checking bench for six_bit_div against an integer division model.
module tb_six_bit_div;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    six_bit_div_if bus ();

    six_bit_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mq(input int a, input int b);
        return (b == 0) ? 63 : a / b;
    endfunction

    function automatic int mr(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Called at a negedge; starts a division and waits for done.
    task automatic div_run(input int a, input int b, input bit full);
        int lat;
        bus.start    = 1'b1;
        bus.dividend = 6'(a);
        bus.divisor  = 6'(b);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        if (full) chk("done_low_after_start", 32'(bus.done), 0);
        while (!bus.done && lat < 20) begin
            if (full) chk("busy_in_run", 32'(bus.busy), 1);
            @(negedge clk);
            lat++;
        end
        if (full || lat != 6) chk("latency", lat, 6);
        if (full) chk("busy_at_done", 32'(bus.busy), 0);
        chk($sformatf("q %0d/%0d", a, b), 32'(bus.quotient), mq(a, b));
        chk($sformatf("r %0d/%0d", a, b), 32'(bus.remainder), mr(a, b));
        chk($sformatf("ovf %0d/%0d", a, b), 32'(bus.overflow), (b == 0));
    endtask

    initial begin
        int dones;
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);

        div_run(13, 4, 1);
        div_run(63, 1, 1);
        div_run(7, 9, 1);
        div_run(0, 5, 1);
        div_run(5, 0, 1);
        div_run(0, 0, 1);
        div_run(40, 8, 1);

        @(negedge clk);
        chk("done_pulse_single", 32'(bus.done), 0);

        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++)
                div_run(a, b, 0);

        repeat (200) div_run($urandom_range(63), $urandom_range(63), 1);
        @(negedge clk);

        // operands change and start re-pulses mid-run
        bus.start    = 1'b1;
        bus.dividend = 6'd50;
        bus.divisor  = 6'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 6'd9;
        bus.divisor  = 6'd2;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done) begin
                dones++;
                chk("mid_q", 32'(bus.quotient), 7);
                chk("mid_r", 32'(bus.remainder), 1);
            end
            @(negedge clk);
        end
        chk("mid_done_count", dones, 1);
        chk("mid_idle_busy", 32'(bus.busy), 0);

        // reset three cycles into a division
        bus.start    = 1'b1;
        bus.dividend = 6'd60;
        bus.divisor  = 6'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_q", 32'(bus.quotient), 0);
        chk("abort_r", 32'(bus.remainder), 0);
        chk("abort_ovf", 32'(bus.overflow), 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        div_run(60, 7, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
